pwm_decoder: RTL and testbench
==============================

Name: pwm_decoder

Overview:
- Receive end of the PWM link. Samples an asynchronous PWM waveform, measures high time and period per cycle, and recovers the 8-bit cutoff (duty) value that a pwm_driver is producing.
- Used for loopback self-test of pwm_driver, and as a generic PWM input capture for external PWM sources.
- Reports duty, measured period and status flags, with a one-cycle valid strobe per completed period.

Parameters:
- DUTY_W, 8, width of the recovered duty value; matches the pwm_driver cutoff width.
- PERIOD, 256, expected PWM period in clk cycles (2**DUTY_W for pwm_driver).
- SYNC_STAGES, 2, input synchronizer depth; must be >= 2.
- TIMEOUT, 512, cycles without a rising edge before the input is declared stuck; must be > PERIOD.

Ports:
- clk, in, 1, system clock; all logic on the rising edge.
- reset, in, 1, asynchronous, active-low reset; asserted when 0.
- pwm_in, in, 1, PWM waveform; asynchronous to clk.
- duty_value, out, DUTY_W, last recovered high-time in cycles, saturated to 2**DUTY_W-1.
- period_value, out, $clog2(TIMEOUT)+1, last measured rise-to-rise period in cycles.
- duty_valid, out, 1, one-cycle pulse when duty_value/period_value update.
- period_err, out, 1, last measured period != PERIOD.
- stuck, out, 1, no rising edge seen for TIMEOUT cycles.
- stuck_level, out, 1, synchronized pwm_in level at stuck entry.

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0, counters 0, synchronizer flops 0, state IDLE.
- Front end: SYNC_STAGES flop chain, then a prev-level flop.
  - rise = sync_out & ~prev.
  - The first clk edge that samples pwm_in high is edge N; rise is true between edges N+SYNC_STAGES-1 and N+SYNC_STAGES.
  - All outputs are registered at edge N+SYNC_STAGES.
- Counters:
  - period_cnt increments every cycle and saturates at TIMEOUT.
  - high_cnt increments while sync_out==1 and saturates at TIMEOUT.
  - Both load 1 on a rise cycle, so the rise cycle itself is counted.
- IDLE: wait for the first rise, then go to MEASURE. No duty_valid on this rise, because the partial period is discarded.
- MEASURE, on rise:
  - duty_value <= min(high_cnt, 2**DUTY_W-1).
  - period_value <= period_cnt.
  - period_err <= (period_cnt != PERIOD).
  - duty_valid pulses for 1 cycle.
  - Counters restart.
- MEASURE, when period_cnt reaches TIMEOUT with no rise, go to STUCK and, in the same update:
  - stuck <= 1 and stuck_level <= sync_out.
  - duty_value <= sync_out ? all-ones : 0.
  - period_value <= 0 and period_err <= 1.
  - duty_valid pulses once.
- IDLE also goes to STUCK after TIMEOUT cycles with no rise (same outputs).
- STUCK:
  - Outputs are held and no further duty_valid pulses.
  - On rise: stuck <= 0, go to MEASURE. No valid for that rise, so the first new measurement comes on the next rise.
  - stuck_level follows sync_out while in STUCK (a falling level with no rise is tracked); duty_value is not re-pulsed.
- Simultaneous rise and period_cnt==TIMEOUT: the rise wins; it is treated as a normal measurement with period_err=1.
- Glitches shorter than 1 clk are not filtered beyond the synchronizer. A 1-cycle high pulse yields duty_value=1.
- Continuous operation: duty_valid cadence equals the input period. A duty change takes effect on the next complete period, with no averaging.

Decomposition:
- Package pwm_pkg: PWM_DUTY_W=8, PWM_PERIOD=256, PWM_TIMEOUT=512 constants, and the enum pwm_dec_state_t {IDLE, MEASURE, STUCK}.
- pwm_driver takes its widths from the same package.
- Sub-module sync_edge_detect (parameter STAGES): outputs level and rise. It is reusable for other asynchronous inputs.

Test Plan:
- pwm_in: 64 high, 192 low, repeated 4 periods -> duty_valid every 256 cycles from the 2nd rise onward; duty_value=64, period_value=256, period_err=0, stuck=0.
- pwm_driver loopback, cutoff 254 then 1, 2, 4 ... 128 (512 cycles each) -> duty_value equals the driver's high-time for each setting within 2 periods of the change, with period_err=0.
- pwm_in held 0 for 600 cycles after valid operation -> stuck=1, stuck_level=0, duty_value=0, period_err=1, exactly one duty_valid at the TIMEOUT cycle. A subsequent square wave clears stuck on the first rise, and the first valid comes on the second rise.
- pwm_in held 1 for 600 cycles -> stuck=1, stuck_level=1, duty_value=255.
- Period 200 with 50 high -> duty_value=50, period_value=200, period_err=1.
- reset pulsed low mid-period (asynchronously, between clk edges) -> all outputs 0 immediately. No duty_valid until two rises after release, and the first reported value comes from a full period.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths and state encoding for the PWM link (driver and decoder).
// Constants only; no latency or flow control.
package pwm_pkg;

    localparam int PWM_DUTY_W  = 8;
    localparam int PWM_PERIOD  = 256;
    localparam int PWM_TIMEOUT = 512;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } pwm_dec_state_t;

    // Counter width able to hold TIMEOUT itself.
    function automatic int pwm_cnt_w(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/pwm_decoder_sync_edge_detect.sv
// Synchronizes an asynchronous level and flags its rising edge.
// Latency: level after STAGES edges, rise for one cycle; no backpressure.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers duty/period of a PWM input per rise-to-rise cycle and flags stuck input.
// Outputs registered SYNC_STAGES edges after pwm_in is sampled high; no backpressure.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int DUTY_W      = PWM_DUTY_W,
    parameter int PERIOD      = PWM_PERIOD,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = PWM_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pwm_in,
    output logic [DUTY_W-1:0]         duty_value,
    output logic [$clog2(TIMEOUT):0]  period_value,
    output logic                      duty_valid,
    output logic                      period_err,
    output logic                      stuck,
    output logic                      stuck_level
);

    localparam int CNT_W = pwm_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] PERIOD_C   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] DUTY_MAX_C = CNT_W'((1 << DUTY_W) - 1);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    logic             w_level;
    logic             w_rise;
    logic             w_timeout;
    logic             w_meas;
    logic             w_stuck_entry;
    logic             w_in_stuck;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    pwm_dec_state_t   r_state;
    pwm_dec_state_t   w_state_nxt;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_async (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise)
    );

    // The rise cycle itself counts as the first cycle of the new period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else if (w_rise) begin
            r_period_cnt <= ONE_C;
            r_high_cnt   <= ONE_C;
        end else begin
            if (r_period_cnt != TIMEOUT_C)
                r_period_cnt <= r_period_cnt + ONE_C;
            if (w_level && r_high_cnt != TIMEOUT_C)
                r_high_cnt <= r_high_cnt + ONE_C;
        end
    end

    assign w_timeout = (r_period_cnt == TIMEOUT_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_state_nxt = MEASURE;
                     else if (w_timeout) w_state_nxt = STUCK;
            MEASURE: if (!w_rise && w_timeout) w_state_nxt = STUCK;
            STUCK:   if (w_rise) w_state_nxt = MEASURE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A rise coinciding with the timeout is a normal (erroneous-period) measurement.
    always_comb begin
        w_meas        = (r_state == MEASURE) && w_rise;
        w_stuck_entry = (r_state != STUCK) && !w_rise && w_timeout;
        w_in_stuck    = (r_state == STUCK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_value   <= '0;
            period_value <= '0;
            duty_valid   <= 1'b0;
            period_err   <= 1'b0;
            stuck        <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            duty_valid <= w_meas | w_stuck_entry;
            if (w_meas) begin
                duty_value   <= (r_high_cnt > DUTY_MAX_C) ? '1 : r_high_cnt[DUTY_W-1:0];
                period_value <= r_period_cnt;
                period_err   <= (r_period_cnt != PERIOD_C);
            end
            if (w_stuck_entry) begin
                stuck        <= 1'b1;
                stuck_level  <= w_level;
                duty_value   <= w_level ? '1 : '0;
                period_value <= '0;
                period_err   <= 1'b1;
            end
            if (w_in_stuck) begin
                stuck_level <= w_level;
                if (w_rise) stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: steady duty, duty changes, off-period, stuck low/high,
// rise-at-timeout and asynchronous reset, with hand-computed expected values.
module tb_pwm_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] duty_value;
    logic [9:0] period_value;
    logic       duty_valid;
    logic       period_err;
    logic       stuck;
    logic       stuck_level;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_vld   = 0;
    int last_vc = 0;
    int prev_vc = 0;

    pwm_decoder u_dut (
        .clk          (clk),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .duty_value   (duty_value),
        .period_value (period_value),
        .duty_valid   (duty_valid),
        .period_err   (period_err),
        .stuck        (stuck),
        .stuck_level  (stuck_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (duty_valid) begin
            n_vld++;
            prev_vc = last_vc;
            last_vc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wave(input int hi, input int lo, input int periods);
        for (int p = 0; p < periods; p++) begin
            pwm_in = 1'b1;
            tick(hi);
            pwm_in = 1'b0;
            tick(lo);
        end
    endtask

    task automatic chk_meas(input string tag, input int vld, input int duty,
                            input int per, input int err);
        chk({tag, "_nvld"},   32'(n_vld), 32'(vld));
        chk({tag, "_duty"},   32'(duty_value), 32'(duty));
        chk({tag, "_period"}, 32'(period_value), 32'(per));
        chk({tag, "_err"},    32'(period_err), 32'(err));
        chk({tag, "_stuck"},  32'(stuck), 32'd0);
    endtask

    initial begin
        tick(3);
        chk("rst_duty",   32'(duty_value), 32'd0);
        chk("rst_period", 32'(period_value), 32'd0);
        chk("rst_valid",  32'(duty_valid), 32'd0);
        chk("rst_flags",  32'({period_err, stuck, stuck_level}), 32'd0);
        reset = 1'b1;
        tick(5);

        // 64/192 at the nominal period: partial first period is discarded.
        n_vld = 0;
        wave(64, 192, 4);
        chk_meas("A", 3, 64, 256, 0);
        chk("A_spacing", 32'(last_vc - prev_vc), 32'd256);

        n_vld = 0;
        wave(10, 246, 2);
        chk_meas("B", 2, 10, 256, 0);

        n_vld = 0;
        wave(1, 255, 2);
        chk_meas("C", 2, 1, 256, 0);

        n_vld = 0;
        wave(255, 1, 2);
        chk_meas("D", 2, 255, 256, 0);

        // Off-nominal period 200 with 50 high.
        n_vld = 0;
        wave(50, 150, 3);
        chk_meas("E", 3, 50, 200, 1);

        // Held low: a single valid exactly TIMEOUT cycles after the last rise.
        n_vld = 0;
        tick(600);
        chk("lo_nvld",   32'(n_vld), 32'd1);
        chk("lo_gap",    32'(last_vc - prev_vc), 32'd512);
        chk("lo_stuck",  32'(stuck), 32'd1);
        chk("lo_level",  32'(stuck_level), 32'd0);
        chk("lo_duty",   32'(duty_value), 32'd0);
        chk("lo_period", 32'(period_value), 32'd0);
        chk("lo_err",    32'(period_err), 32'd1);

        // Recovery: first rise clears stuck silently, second rise reports.
        n_vld = 0;
        wave(64, 192, 1);
        chk("F1_nvld",  32'(n_vld), 32'd0);
        chk("F1_stuck", 32'(stuck), 32'd0);
        wave(64, 192, 1);
        chk_meas("F2", 1, 64, 256, 0);

        // Held high: rise reports the last full period, then timeout.
        n_vld = 0;
        pwm_in = 1'b1;
        tick(600);
        chk("hi_nvld",   32'(n_vld), 32'd2);
        chk("hi_stuck",  32'(stuck), 32'd1);
        chk("hi_level",  32'(stuck_level), 32'd1);
        chk("hi_duty",   32'(duty_value), 32'd255);
        chk("hi_period", 32'(period_value), 32'd0);
        chk("hi_err",    32'(period_err), 32'd1);

        // Falling level while stuck is tracked without a new valid.
        n_vld = 0;
        pwm_in = 1'b0;
        tick(10);
        chk("fall_level", 32'(stuck_level), 32'd0);
        chk("fall_stuck", 32'(stuck), 32'd1);
        chk("fall_nvld",  32'(n_vld), 32'd0);
        chk("fall_duty",  32'(duty_value), 32'd255);

        // Asynchronous reset in the middle of a high phase.
        n_vld = 0;
        wave(64, 192, 2);
        chk_meas("H", 1, 64, 256, 0);
        pwm_in = 1'b1;
        tick(30);
        #3 reset = 1'b0;
        #1;
        chk("arst_duty",   32'(duty_value), 32'd0);
        chk("arst_period", 32'(period_value), 32'd0);
        chk("arst_flags",  32'({duty_valid, period_err, stuck, stuck_level}), 32'd0);
        pwm_in = 1'b0;
        tick(3);
        reset = 1'b1;
        n_vld = 0;
        tick(100);
        wave(64, 192, 1);
        chk("post_rst_nvld1", 32'(n_vld), 32'd0);
        wave(64, 192, 1);
        chk_meas("post_rst", 1, 64, 256, 0);
        wave(64, 192, 1);

        // Rise exactly at the timeout cycle is a measurement, not a stuck entry.
        n_vld = 0;
        wave(100, 412, 2);
        chk_meas("rt", 2, 100, 512, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
